output_holder_ctrl: RTL and testbench

OUTPUT_HOLDER_CTRL -- requirements
Module: output_holder_ctrl

---
 rtl/output_holder_ctrl.sv | 134 +++++++++++++
 tb/tb_output_holder_ctrl.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/output_holder_ctrl.sv
// Output holder: buffers cipher bytes in a small FIFO and hands them to the pins
// with a four-phase ready/acknowledge handshake. Optional macro: OUTPUT_ACK_SYNC_EN.

package output_holder_pkg;
  typedef enum logic [1:0] {
    O_EMPTY        = 2'd0,
    O_READY        = 2'd1,
    O_WAIT_RELEASE = 2'd2
  } output_holder_state_t;
endpackage

module output_holder_ctrl
  import output_holder_pkg::*;
#(
  parameter int BUF_DEPTH = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [7:0]           byte_in,
  input  logic                 byte_valid,
  output logic                 byte_accept,
  input  logic                 clear,
  input  logic                 output_acknowledge,
  output logic [7:0]           byte_out,
  output logic                 output_byte_is_ready,
  output output_holder_state_t holder_state,
  output logic                 overflow
);

  localparam int PTR_W = $clog2(BUF_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  // Handshake: the cipher side pushes when byte_valid && byte_accept; the user
  // side sees a byte while output_byte_is_ready=1, raises output_acknowledge to
  // take it, and must drop it again before the next byte is offered.

  logic [7:0]       mem [BUF_DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] count;
  logic             nonempty_q;
  logic             ack_s, ack_q, ack_rise;
  logic             full, empty, push, pop, drop;

  output_holder_state_t state_q, state_d;

`ifdef OUTPUT_ACK_SYNC_EN
  logic ack_s1, ack_s2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ack_s1 <= 1'b0;
      ack_s2 <= 1'b0;
    end else begin
      ack_s1 <= output_acknowledge;
      ack_s2 <= ack_s1;
    end
  end

  assign ack_s = ack_s2;
`else
  assign ack_s = output_acknowledge;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ack_q <= 1'b0;
    else        ack_q <= ack_s;
  end

  assign ack_rise = ack_s & ~ack_q;

  assign full  = (count == CNT_W'(BUF_DEPTH));
  assign empty = (count == '0);
  assign pop   = (state_q == O_READY) && ack_rise && !empty;
  // A full buffer still takes a byte when the head leaves on the same edge.
  assign push  = byte_valid && !clear && (!full || pop);
  assign drop  = byte_valid && !clear && full && !pop;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= byte_in;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      overflow   <= 1'b0;
      nonempty_q <= 1'b0;
    end else if (clear) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      overflow   <= 1'b0;
      nonempty_q <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (drop) overflow <= 1'b1;
      nonempty_q <= !empty;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= O_EMPTY;
    else        state_q <= state_d;
  end

  // Leaving O_EMPTY waits for the byte to have sat at the head for a full
  // cycle, so the pins settle before ready is raised.
  always_comb begin
    state_d = state_q;
    if (clear) begin
      state_d = O_EMPTY;
    end else begin
      case (state_q)
        O_EMPTY:        if (nonempty_q && !empty) state_d = O_READY;
        O_READY:        if (pop) state_d = O_WAIT_RELEASE;
        O_WAIT_RELEASE: if (!ack_s) state_d = empty ? O_EMPTY : O_READY;
        default:        state_d = O_EMPTY;
      endcase
    end
  end

  assign byte_accept          = !full;
  assign byte_out             = empty ? 8'h00 : mem[rd_ptr];
  assign output_byte_is_ready = (state_q == O_READY);
  assign holder_state         = state_q;

endmodule

// File: tb/tb_output_holder_ctrl.sv
// Self-checking bench for output_holder_ctrl: directed handshake scenarios plus
// randomized traffic compared against a queue-based reference model.

module tb_output_holder_ctrl;
  import output_holder_pkg::*;

  localparam int DEPTH = 2;
`ifdef OUTPUT_ACK_SYNC_EN
  localparam int ACK_LAT = 2;
  localparam bit SYNC    = 1'b1;
`else
  localparam int ACK_LAT = 0;
  localparam bit SYNC    = 1'b0;
`endif

  logic                 clk;
  logic                 rst_n;
  logic [7:0]           byte_in;
  logic                 byte_valid;
  logic                 byte_accept;
  logic                 clear;
  logic                 output_acknowledge;
  logic [7:0]           byte_out;
  logic                 output_byte_is_ready;
  output_holder_state_t holder_state;
  logic                 overflow;

  output_holder_ctrl #(.BUF_DEPTH(DEPTH)) dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .byte_in             (byte_in),
    .byte_valid          (byte_valid),
    .byte_accept         (byte_accept),
    .clear               (clear),
    .output_acknowledge  (output_acknowledge),
    .byte_out            (byte_out),
    .output_byte_is_ready(output_byte_is_ready),
    .holder_state        (holder_state),
    .overflow            (overflow)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // reference model: byte queue plus handshake phase
  logic [7:0]           exp_q[$];
  output_holder_state_t m_st;
  bit                   m_ovf;
  bit                   m_seen;   // head byte has been present for a full cycle
  bit                   m_ackq, m_s1, m_s2;

  task automatic model_reset();
    exp_q.delete();
    m_st   = O_EMPTY;
    m_ovf  = 1'b0;
    m_seen = 1'b0;
    m_ackq = 1'b0;
    m_s1   = 1'b0;
    m_s2   = 1'b0;
  endtask

  task automatic model_edge();
    bit as, pop;
    int sz;
    as = SYNC ? m_s2 : output_acknowledge;
    sz = exp_q.size();
    if (clear) begin
      exp_q.delete();
      m_ovf  = 1'b0;
      m_st   = O_EMPTY;
      m_seen = 1'b0;
    end else begin
      pop = (m_st == O_READY) && as && !m_ackq && (sz != 0);
      case (m_st)
        O_EMPTY:        if (m_seen && sz != 0) m_st = O_READY;
        O_READY:        if (pop) m_st = O_WAIT_RELEASE;
        default:        if (!as) m_st = (sz != 0) ? O_READY : O_EMPTY;
      endcase
      if (pop) void'(exp_q.pop_front());
      if (byte_valid) begin
        if (sz < DEPTH || pop) exp_q.push_back(byte_in);
        else m_ovf = 1'b1;
      end
      m_seen = (sz != 0);
    end
    m_ackq = as;
    m_s2   = m_s1;
    m_s1   = output_acknowledge;
  endtask

  task automatic check_outputs();
    check("ready",    32'(output_byte_is_ready), 32'(m_st == O_READY));
    check("byte_out", 32'(byte_out),             (exp_q.size() != 0) ? 32'(exp_q[0]) : 32'h0);
    check("accept",   32'(byte_accept),          32'(exp_q.size() < DEPTH));
    check("overflow", 32'(overflow),             32'(m_ovf));
    check("state",    32'(holder_state),         32'(m_st));
  endtask

  // driver tasks: called at a falling edge, return at the next falling edge
  task automatic cycle(input bit v, input logic [7:0] b, input bit clr, input bit ack);
    byte_valid         = v;
    byte_in            = b;
    clear              = clr;
    output_acknowledge = ack;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_outputs();
  endtask

  task automatic idle(input int n, input bit ack);
    for (int i = 0; i < n; i++) cycle(1'b0, 8'h00, 1'b0, ack);
  endtask

  task automatic ack_pulse();
    idle(ACK_LAT + 1, 1'b1);
    idle(ACK_LAT + 2, 1'b0);
  endtask

  task automatic do_reset(input bit ack);
    output_acknowledge = ack;
    rst_n = 1'b0;
    #1;
    model_reset();
    check("rst_ready",    32'(output_byte_is_ready), 32'h0);
    check("rst_byte_out", 32'(byte_out),             32'h0);
    check("rst_accept",   32'(byte_accept),          32'h1);
    check("rst_state",    32'(holder_state),         32'(O_EMPTY));
    check("rst_overflow", 32'(overflow),             32'h0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int lat;
    int hold;
    bit ack_r;
    rst_n = 1'b0;
    byte_in = 8'h00;
    byte_valid = 1'b0;
    clear = 1'b0;
    output_acknowledge = 1'b0;
    @(negedge clk);
    do_reset(1'b0);

    // single byte and ack latency
    cycle(1'b1, 8'hA5, 1'b0, 1'b0);
    idle(1, 1'b0);
    check("a5_not_yet", 32'(output_byte_is_ready), 32'h0);
    idle(1, 1'b0);
    check("a5_ready", 32'(output_byte_is_ready), 32'h1);
    check("a5_byte",  32'(byte_out), 32'hA5);
    lat = 0;
    while (output_byte_is_ready && lat < 10) begin
      idle(1, 1'b1);
      lat++;
    end
    check("ack_latency", 32'(lat), 32'(ACK_LAT + 1));
    idle(ACK_LAT + 2, 1'b0);
    check("a5_done", 32'(holder_state), 32'(O_EMPTY));

    // back-to-back fill and overflow
    cycle(1'b1, 8'h11, 1'b0, 1'b0);
    cycle(1'b1, 8'h22, 1'b0, 1'b0);
    check("full_accept", 32'(byte_accept), 32'h0);
    cycle(1'b1, 8'h33, 1'b0, 1'b0);
    check("ovf_set", 32'(overflow), 32'h1);
    check("first_11", 32'(byte_out), 32'h11);
    ack_pulse();
    check("second_22", 32'(byte_out), 32'h22);
    check("second_rdy", 32'(output_byte_is_ready), 32'h1);
    ack_pulse();
    check("drained", 32'(holder_state), 32'(O_EMPTY));
    cycle(1'b0, 8'h00, 1'b1, 1'b0);
    check("ovf_clr", 32'(overflow), 32'h0);

    // held acknowledge pops once
    cycle(1'b1, 8'hAA, 1'b0, 1'b0);
    cycle(1'b1, 8'hBB, 1'b0, 1'b0);
    idle(1, 1'b0);
    idle(10, 1'b1);
    check("held_state",  32'(holder_state), 32'(O_WAIT_RELEASE));
    check("held_accept", 32'(byte_accept), 32'h1);
    idle(ACK_LAT + 2, 1'b0);
    check("held_next", 32'(byte_out), 32'hBB);
    check("held_rdy",  32'(output_byte_is_ready), 32'h1);
    ack_pulse();

    // push into a full buffer on the pop edge
    cycle(1'b1, 8'h01, 1'b0, 1'b0);
    cycle(1'b1, 8'h02, 1'b0, 1'b0);
    idle(1, 1'b0);
    idle(ACK_LAT, 1'b1);
    cycle(1'b1, 8'h44, 1'b0, 1'b1);
    check("sim_accept", 32'(byte_accept), 32'h0);
    check("sim_ovf",    32'(overflow), 32'h0);
    idle(ACK_LAT + 2, 1'b0);
    check("sim_02", 32'(byte_out), 32'h02);
    ack_pulse();
    check("sim_44", 32'(byte_out), 32'h44);
    ack_pulse();

    // clear with data buffered, then reset during O_READY with ack held high
    cycle(1'b1, 8'h55, 1'b0, 1'b0);
    cycle(1'b1, 8'h66, 1'b0, 1'b0);
    cycle(1'b0, 8'h00, 1'b1, 1'b0);
    check("clr_accept", 32'(byte_accept), 32'h1);
    check("clr_state",  32'(holder_state), 32'(O_EMPTY));
    cycle(1'b1, 8'h77, 1'b0, 1'b0);
    idle(2, 1'b0);
    check("pre_rst_rdy", 32'(output_byte_is_ready), 32'h1);
    do_reset(1'b1);
    idle(5, 1'b1);
    check("post_rst_rdy", 32'(output_byte_is_ready), 32'h0);
    idle(ACK_LAT + 2, 1'b0);

    // randomized traffic
    hold = 0;
    ack_r = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (hold == 0) begin
        ack_r = ~ack_r;
        hold = $urandom_range(1, 6);
      end
      hold--;
      cycle(1'($urandom_range(0, 1)), 8'($urandom), ($urandom_range(0, 29) == 0), ack_r);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
